// File: rtl/ser_link_pkg.sv
// Shared constants and types for the serial link receive path.
// Frame layout: start, A (MSB first), separator, D (MSB first), separator, stop.
package ser_link_pkg;

    localparam int unsigned SIZE_A    = 7;
    localparam int unsigned SIZE_D    = 8;
    localparam int unsigned FRAME_LEN = SIZE_A + SIZE_D + 4;
    localparam int unsigned CNT_W     = $clog2(FRAME_LEN);

    typedef logic [CNT_W-1:0] bit_cnt_t;

    localparam bit_cnt_t START_POS = bit_cnt_t'(0);
    localparam bit_cnt_t SEP1_POS  = bit_cnt_t'(SIZE_A + 1);
    localparam bit_cnt_t SEP2_POS  = bit_cnt_t'(SIZE_A + SIZE_D + 2);
    localparam bit_cnt_t STOP_POS  = bit_cnt_t'(FRAME_LEN - 1);

    typedef enum logic [1:0] {IDLE, RECV, DONE} rx_state_t;

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Valid/ready output bus carrying one recovered A/D frame to the consumer.
interface serial_frame_receiver_if
    import ser_link_pkg::*;
();

    logic [SIZE_A-1:0] A_out;
    logic [SIZE_D-1:0] D_out;
    logic              Valid;
    logic              Ready;

    modport master (output A_out, output D_out, output Valid, input Ready);
    modport slave  (input A_out, input D_out, input Valid, output Ready);

endinterface

// File: rtl/ser_edge_sync.sv
// Synchronises the link clock/data lines into clk_in and flags falling edges
// of the link clock together with the data bit to sample on that edge.
module ser_edge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_in,
    input  logic reset,
    input  logic ser_c,
    input  logic ser_d,
    output logic fall,
    output logic data_bit
);

    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("SYNC_STAGES must be at least 2");
    end

    logic [SYNC_STAGES-1:0] c_sync_q;
    logic [SYNC_STAGES-1:0] d_sync_q;
    logic                   c_prev_q;

    // Reset to the idle-high level so leaving reset never fakes an edge.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            c_sync_q <= '1;
            d_sync_q <= '1;
            c_prev_q <= 1'b1;
        end else begin
            c_sync_q <= {c_sync_q[SYNC_STAGES-2:0], ser_c};
            d_sync_q <= {d_sync_q[SYNC_STAGES-2:0], ser_d};
            c_prev_q <= c_sync_q[SYNC_STAGES-1];
        end
    end

    assign fall     = c_prev_q & ~c_sync_q[SYNC_STAGES-1];
    assign data_bit = d_sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/serial_frame_receiver.sv
// Rebuilds A/D words from 19-bit serial link frames and hands them off through
// a one-entry valid/ready register. Define SER_RX_TIMEOUT_EN to abort stalled frames.
module serial_frame_receiver
    import ser_link_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 64
) (
    input  logic                     clk_in,
    input  logic                     reset,
    input  logic                     SerC,
    input  logic                     SerD,
    serial_frame_receiver_if.master  rx_bus,
    output logic                     FrameErr,
    output logic                     Overrun,
    output logic                     Busy
);

    if (TIMEOUT < 2) begin : g_bad_timeout
        $error("TIMEOUT must be at least 2");
    end

    logic fall;
    logic data_bit;

    ser_edge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_edge_sync (
        .clk_in   (clk_in),
        .reset    (reset),
        .ser_c    (SerC),
        .ser_d    (SerD),
        .fall     (fall),
        .data_bit (data_bit)
    );

    rx_state_t         state_q;
    bit_cnt_t          bit_cnt_q;
    logic [SIZE_A-1:0] a_sh_q;
    logic [SIZE_D-1:0] d_sh_q;
    logic [SIZE_A-1:0] a_q;
    logic [SIZE_D-1:0] d_q;
    logic              valid_q;
    logic              frame_err_q;
    logic              overrun_q;
    logic              busy_q;

`ifdef SER_RX_TIMEOUT_EN
    localparam int unsigned IDLE_W = $clog2(TIMEOUT);
    logic [IDLE_W-1:0] idle_q;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            a_sh_q      <= '0;
            d_sh_q      <= '0;
            a_q         <= '0;
            d_q         <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
`ifdef SER_RX_TIMEOUT_EN
            idle_q      <= '0;
`endif
        end else begin
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            if (valid_q && rx_bus.Ready) valid_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (fall && !data_bit) begin
                        state_q   <= RECV;
                        bit_cnt_q <= bit_cnt_t'(1);
                        busy_q    <= 1'b1;
`ifdef SER_RX_TIMEOUT_EN
                        idle_q    <= '0;
`endif
                    end
                end
                RECV: begin
                    if (fall) begin
`ifdef SER_RX_TIMEOUT_EN
                        idle_q <= '0;
`endif
                        if (bit_cnt_q == STOP_POS) begin
                            bit_cnt_q <= '0;
                            if (!data_bit) begin
                                state_q <= DONE;
                            end else begin
                                frame_err_q <= 1'b1;
                                state_q     <= IDLE;
                                busy_q      <= 1'b0;
                            end
                        end else begin
                            // Separator positions fall through both ranges and are dropped.
                            if (bit_cnt_q > START_POS && bit_cnt_q < SEP1_POS)
                                a_sh_q <= {a_sh_q[SIZE_A-2:0], data_bit};
                            if (bit_cnt_q > SEP1_POS && bit_cnt_q < SEP2_POS)
                                d_sh_q <= {d_sh_q[SIZE_D-2:0], data_bit};
                            bit_cnt_q <= bit_cnt_q + bit_cnt_t'(1);
                        end
                    end
`ifdef SER_RX_TIMEOUT_EN
                    else if (idle_q == IDLE_W'(TIMEOUT - 1)) begin
                        frame_err_q <= 1'b1;
                        state_q     <= IDLE;
                        busy_q      <= 1'b0;
                        bit_cnt_q   <= '0;
                    end else begin
                        idle_q <= idle_q + IDLE_W'(1);
                    end
`endif
                end
                DONE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    // A consumer taking the held frame this cycle frees the slot.
                    if (!valid_q || rx_bus.Ready) begin
                        a_q     <= a_sh_q;
                        d_q     <= d_sh_q;
                        valid_q <= 1'b1;
                    end else begin
                        overrun_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign rx_bus.A_out = a_q;
    assign rx_bus.D_out = d_q;
    assign rx_bus.Valid = valid_q;
    assign FrameErr     = frame_err_q;
    assign Overrun      = overrun_q;
    assign Busy         = busy_q;

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Randomised frame bench for serial_frame_receiver: a behavioural sender drives
// the link and a queue of expected A/D words is checked at every handshake.
module tb_serial_frame_receiver;

    logic clk_in = 1'b0;
    logic reset;
    logic SerC;
    logic SerD;
    logic FrameErr;
    logic Overrun;
    logic Busy;

    serial_frame_receiver_if rx_bus ();

    serial_frame_receiver u_dut (
        .clk_in   (clk_in),
        .reset    (reset),
        .SerC     (SerC),
        .SerD     (SerD),
        .rx_bus   (rx_bus),
        .FrameErr (FrameErr),
        .Overrun  (Overrun),
        .Busy     (Busy)
    );

    always #5 clk_in = ~clk_in;

    int unsigned n_checks = 0;
    int unsigned n_bad    = 0;
    int unsigned ferr_seen = 0;
    int unsigned ovr_seen  = 0;
    int unsigned acc_seen  = 0;
    int unsigned exp_ferr  = 0;
    int unsigned exp_ovr   = 0;
    int unsigned exp_acc   = 0;
    logic [14:0] exp_q[$];
    logic        ferr_prev = 1'b0;
    logic        ovr_prev  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Consumer side: every accepted word must be the oldest outstanding frame.
    always @(negedge clk_in) begin
        if (!reset) begin
            if (rx_bus.Valid && rx_bus.Ready) begin
                acc_seen++;
                if (exp_q.size() == 0) begin
                    check_eq("unexpected_frame", {17'd0, rx_bus.A_out, rx_bus.D_out}, 32'hFFFF_FFFF);
                end else begin
                    check_eq("frame_data", {17'd0, rx_bus.A_out, rx_bus.D_out},
                             {17'd0, exp_q.pop_front()});
                end
            end
            if (FrameErr) begin
                ferr_seen++;
                check_eq("ferr_width", {31'd0, ferr_prev}, 32'd0);
            end
            if (Overrun) begin
                ovr_seen++;
                check_eq("ovr_width", {31'd0, ovr_prev}, 32'd0);
            end
            ferr_prev = FrameErr;
            ovr_prev  = Overrun;
        end
    end

    // Sends the first nbits of a frame; separators: 0, 1 or X per sep_mode.
    task automatic send_frame(input logic [6:0] a, input logic [7:0] d, input int sep_mode,
                              input logic stop, input int nbits, input bit chk_lat);
        logic fb [19];
        logic sepv;
        sepv = (sep_mode == 0) ? 1'b0 : (sep_mode == 1) ? 1'b1 : 1'bx;
        fb[0] = 1'b0;
        for (int i = 0; i < 7; i++) fb[1 + i] = a[6 - i];
        fb[8] = sepv;
        for (int i = 0; i < 8; i++) fb[9 + i] = d[7 - i];
        fb[17] = sepv;
        fb[18] = stop;
        for (int b = 0; b < nbits; b++) begin
            SerD = fb[b];
            repeat ($urandom_range(2, 4)) @(negedge clk_in);
            SerC = 1'b0;
            if (b == 18 && chk_lat) begin
                repeat (3) @(negedge clk_in);
                check_eq("busy_done", {31'd0, Busy}, {31'd0, !stop});
                check_eq("ferr_stop", {31'd0, FrameErr}, {31'd0, stop});
                @(negedge clk_in);
                check_eq("valid_lat", {31'd0, rx_bus.Valid}, {31'd0, !stop});
                check_eq("busy_end", {31'd0, Busy}, 32'd0);
            end else begin
                repeat ($urandom_range(2, 4)) @(negedge clk_in);
            end
            SerC = 1'b1;
        end
        SerD = 1'b1;
    endtask

    // Full frame with Ready=1 and an empty slot: update the model, then send.
    task automatic frame(input logic [6:0] a, input logic [7:0] d, input int sep_mode,
                         input logic stop);
        if (stop) exp_ferr++;
        else begin
            exp_q.push_back({a, d});
            exp_acc++;
        end
        send_frame(a, d, sep_mode, stop, 19, 1'b1);
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, "_a"}, {25'd0, rx_bus.A_out}, 32'd0);
        check_eq({tag, "_d"}, {24'd0, rx_bus.D_out}, 32'd0);
        check_eq({tag, "_valid"}, {31'd0, rx_bus.Valid}, 32'd0);
        check_eq({tag, "_ferr"}, {31'd0, FrameErr}, 32'd0);
        check_eq({tag, "_ovr"}, {31'd0, Overrun}, 32'd0);
        check_eq({tag, "_busy"}, {31'd0, Busy}, 32'd0);
    endtask

    task automatic pulse_reset();
        @(negedge clk_in);
        reset = 1'b1;
        @(negedge clk_in);
        check_all_zero("rst_pulse");
        reset = 1'b0;
        @(negedge clk_in);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "simulation watchdog expired");
    end

    initial begin
        logic [6:0] ra;
        logic [7:0] rd;
        reset = 1'b1;
        SerC = 1'b1;
        SerD = 1'b1;
        rx_bus.Ready = 1'b1;
        repeat (4) @(negedge clk_in);
        check_all_zero("reset");
        reset = 1'b0;
        repeat (3) @(negedge clk_in);

        frame(7'h7F, 8'hFF, 0, 1'b0);
        frame(7'h41, 8'h9F, 0, 1'b0);
        frame(7'h41, 8'h9F, 1, 1'b0);
        frame(7'h41, 8'h9F, 2, 1'b0);
        frame(7'h55, 8'hAA, 1, 1'b1);
        frame(7'h2A, 8'h55, 0, 1'b0);

        for (int n = 0; n < 12; n++) begin
            ra = 7'($urandom);
            rd = 8'($urandom);
            frame(ra, rd, int'($urandom_range(0, 2)), ($urandom_range(0, 4) == 0));
        end

        // Consumer stalled: first frame held, second dropped with Overrun.
        repeat (3) @(negedge clk_in);
        rx_bus.Ready = 1'b0;
        send_frame(7'h41, 8'h9F, 0, 1'b0, 19, 1'b0);
        send_frame(7'h2A, 8'h55, 1, 1'b0, 19, 1'b0);
        exp_ovr++;
        repeat (6) @(negedge clk_in);
        check_eq("held_valid", {31'd0, rx_bus.Valid}, 32'd1);
        check_eq("held_a", {25'd0, rx_bus.A_out}, 32'h41);
        check_eq("held_d", {24'd0, rx_bus.D_out}, 32'h9F);
        exp_q.push_back({7'h41, 8'h9F});
        exp_acc++;
        rx_bus.Ready = 1'b1;
        repeat (3) @(negedge clk_in);
        check_eq("held_drained", {31'd0, rx_bus.Valid}, 32'd0);

        // Reset mid-frame with a frame also held: both are discarded.
        rx_bus.Ready = 1'b0;
        send_frame(7'h33, 8'hCC, 0, 1'b0, 19, 1'b0);
        send_frame(7'h12, 8'h34, 0, 1'b0, 11, 1'b0);
        repeat (2) @(negedge clk_in);
        check_eq("pre_rst_busy", {31'd0, Busy}, 32'd1);
        rx_bus.Ready = 1'b1;
        reset = 1'b1;
        @(negedge clk_in);
        check_all_zero("mid_reset");
        reset = 1'b0;
        repeat (2) @(negedge clk_in);
        frame(7'h5A, 8'hC3, 1, 1'b0);

        // Link clock stalls high after bit 5.
        send_frame(7'h00, 8'h00, 0, 1'b0, 6, 1'b0);
        repeat (100) @(negedge clk_in);
`ifdef SER_RX_TIMEOUT_EN
        exp_ferr++;
        check_eq("timeout_busy", {31'd0, Busy}, 32'd0);
`else
        check_eq("stall_busy", {31'd0, Busy}, 32'd1);
`endif
        pulse_reset();
        frame(7'h41, 8'h9F, 2, 1'b0);

        repeat (10) @(negedge clk_in);
        check_eq("ferr_count", ferr_seen, exp_ferr);
        check_eq("ovr_count", ovr_seen, exp_ovr);
        check_eq("acc_count", acc_seen, exp_acc);
        check_eq("queue_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/serial_frame_receiver.md
# serial_frame_receiver

Receive-side stage of the serial output link: consumes the `OutD`/`OutC` pair produced by the serial output buffer and rebuilds the 7-bit `A` and 8-bit `D` words from each 19-bit frame. The frame is start `0`, `A` MSB first, a separator bit, `D` MSB first, a separator bit, and stop `0`. The block runs on its own local clock, synchronises both link lines, and samples data on each falling edge of the link clock. Each recovered frame is presented to a downstream consumer through a valid/ready register.

## Interface
- `SIZE_A`, 7, width of the A field
- `SIZE_D`, 8, width of the D field
- `SYNC_STAGES`, 2, flip-flop depth of the input synchronisers (≥2)
- `TIMEOUT`, 64, local clocks without a link-clock falling edge before a partial frame is aborted
- `clk_in` in 1: local clock. One clock only.
- `reset` in 1: reset is synchronous and active-high.
- `SerC` in 1: link clock, driven from sender `OutC`; idles high.
- `SerD` in 1: link data, driven from sender `OutD`.
- `A_out` out SIZE_A: recovered A field.
- `D_out` out SIZE_D: recovered D field.
- `Valid` out 1: `A_out`/`D_out` hold an unconsumed frame.
- `Ready` in 1: consumer accepts the frame when `Valid && Ready`.
- `FrameErr` out 1: one-cycle pulse on a bad stop bit or timeout.
- `Overrun` out 1: one-cycle pulse when a good frame is dropped.
- `Busy` out 1: frame reception in progress.

## Operation
- Derived constant: `FRAME_LEN = SIZE_A + SIZE_D + 4` (19).
- Bit positions: start 0; A 1..7; separator 8; D 9..16; separator 17; stop 18.
- `SerC` and `SerD` each pass through `SYNC_STAGES` flip-flops; synchroniser reset value is `1`.
- Falling edge (`fall`): previous synced `SerC` is 1 and current synced `SerC` is 0. On `fall`, the bit taken is the synced `SerD` of the same cycle.
- State machine:
  - IDLE: on `fall` with bit=0, go to RECV with `bit_cnt`=1. On `fall` with bit=1, stay in IDLE (this is how the receiver hunts for a start bit).
  - RECV: each `fall` stores the bit at `bit_cnt` and increments `bit_cnt`.
    - Separator bits are discarded; their value is don't-care because the sender drives Z.
    - When `bit_cnt`=18, evaluate the stop bit:
      - stop=0: go to DONE.
      - stop=1: pulse `FrameErr`, discard the frame, go to IDLE.
  - DONE: lasts one cycle, then returns to IDLE. See the delivery rules below.
- Delivery, evaluated in the DONE cycle:
  - If `Valid`=0, or `Valid && Ready` in the same cycle: load the output register and set `Valid`=1.
  - Otherwise: keep the old data, keep `Valid`=1, pulse `Overrun`, drop the new frame.
- `Valid` clears on `Valid && Ready` when there is no simultaneous load.
- `Busy`=1 in RECV and DONE.
- Reset values: `A_out`=0, `D_out`=0, `Valid`=0, `FrameErr`=0, `Overrun`=0, `Busy`=0. State is IDLE and `bit_cnt`=0.
- Reset mid-frame discards the partial frame and any held frame. It never produces `FrameErr` and never produces a spurious `fall`.

## Timing
- Requirement: every `SerC` high and low phase lasts ≥2 `clk_in` periods, i.e. `clk_in` is ≥4× the sender clock.
- A `SerC` falling edge meeting setup is seen as `fall` `SYNC_STAGES`+1 rising edges later.
- `Valid` rises on the rising edge after DONE: 2 cycles after the `fall` of the stop bit.
- `FrameErr` and `Overrun` are high for exactly one cycle.
- Back-to-back frames: the next start bit may arrive any time after DONE. No gap is required beyond the sender's own framing.

## Configuration
- `SER_RX_TIMEOUT_EN` defined:
  - In RECV, an idle counter resets on each `fall`.
  - When it reaches `TIMEOUT`-1 with no `fall`, pulse `FrameErr` and return to IDLE.
- Not defined:
  - No counter is built.
  - A partial frame waits indefinitely in RECV for further edges or `reset`.

## Structure
- Package `ser_link_pkg` holds:
  - `SIZE_A`, `SIZE_D`, `FRAME_LEN`
  - bit-position constants (`START_POS`, `SEP1_POS`, `SEP2_POS`, `STOP_POS`)
  - state enum {IDLE, RECV, DONE}
- Sub-module `ser_edge_sync` contains the `SerC`/`SerD` synchronisers and the `fall` detector. It outputs `fall` and `bit`.

## Test plan
- Sender frame A=7'b1111111, D=8'b11111111, `Ready`=1 -> `Valid` pulses once; `A_out`=7'h7F, `D_out`=8'hFF; no `FrameErr`.
- Frame A=7'b1000001, D=8'b10011111, with separators driven 0, 1, and X -> `A_out`=7'h41, `D_out`=8'h9F in every case.
- Two frames (7'h41/8'h9F then 7'h2A/8'h55) with `Ready`=0 -> first frame is held; `Overrun` pulses once at the second DONE; `Ready`=1 afterwards accepts 7'h41/8'h9F.
- Stop bit forced to 1 -> `FrameErr` pulses one cycle; `Valid` stays 0; the next good frame is received correctly.
- `SerC` stops high after bit 5, with `SER_RX_TIMEOUT_EN` -> `FrameErr` 64 cycles after the last `fall`, then `Busy`=0. Without the macro -> `Busy` stays 1.
- `reset` asserted at bit 10 -> next cycle all outputs are 0 and `Busy`=0; the following frame decodes correctly.
